// File: rtl/regfile_pkg.sv
// Shared constants and types for the scoreboarded register file.
// The optional same-cycle write bypass is enabled by defining REGFILE_SB_BYPASS_EN.
package regfile_pkg;

    localparam int REGFILE_XLEN  = 32;
    localparam int REGFILE_NREGS = 32;
    localparam int REGFILE_AW    = $clog2(REGFILE_NREGS);

    typedef logic [REGFILE_AW-1:0]   reg_idx_t;
    typedef logic [REGFILE_XLEN-1:0] word_t;

endpackage

// File: rtl/regfile_sb_if.sv
// Read, writeback, issue and scoreboard-status bundle of the register file.
// The master drives addresses, write data and issue requests; the slave is the register file.
interface regfile_sb_if
    import regfile_pkg::*;
#(
    parameter int XLEN  = REGFILE_XLEN,
    parameter int NREGS = REGFILE_NREGS
) ();

    localparam int AW = $clog2(NREGS);

    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic            we;
    logic [AW-1:0]   wa;
    logic [XLEN-1:0] wd;
    logic            issue_valid;
    logic [AW-1:0]   issue_rd;
    logic            flush;
    logic            rs1_busy;
    logic            rs2_busy;
    logic            stall;
    logic [AW:0]     busy_cnt;

    modport master (
        output rs1, rs2, we, wa, wd, issue_valid, issue_rd, flush,
        input  rd1, rd2, rs1_busy, rs2_busy, stall, busy_cnt
    );

    modport slave (
        input  rs1, rs2, we, wa, wd, issue_valid, issue_rd, flush,
        output rd1, rd2, rs1_busy, rs2_busy, stall, busy_cnt
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: tracks pending producers, counts them and raises stall.
// With REGFILE_SB_BYPASS_EN, an operand being written this cycle is reported not busy.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS = REGFILE_NREGS,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] i_rs1,
    input  logic [AW-1:0] i_rs2,
    input  logic          i_we,
    input  logic [AW-1:0] i_wa,
    input  logic          i_issue_valid,
    input  logic [AW-1:0] i_issue_rd,
    input  logic          i_flush,
    output logic          o_rs1_busy,
    output logic          o_rs2_busy,
    output logic          o_stall,
    output logic [AW:0]   o_busy_cnt
);

    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_busy_nxt;
    logic [AW:0]      r_cnt;
    logic [AW:0]      w_cnt_nxt;
    logic             w_wr;
    logic             w_byp1;
    logic             w_byp2;
    logic             w_rs1_busy;
    logic             w_rs2_busy;
    logic             w_waw;
    logic             w_stall;
    logic             w_set;
    logic             w_inc;
    logic             w_dec;

    assign w_wr = i_we && (i_wa != '0);

`ifdef REGFILE_SB_BYPASS_EN
    assign w_byp1 = w_wr && (i_wa == i_rs1);
    assign w_byp2 = w_wr && (i_wa == i_rs2);
`else
    assign w_byp1 = 1'b0;
    assign w_byp2 = 1'b0;
`endif

    assign w_rs1_busy = (i_rs1 != '0) && r_busy[i_rs1] && !w_byp1;
    assign w_rs2_busy = (i_rs2 != '0) && r_busy[i_rs2] && !w_byp2;

    // A writeback retiring the old producer this cycle resolves the WAW hazard,
    // so the new issue may claim the register in the same cycle.
    assign w_waw   = r_busy[i_issue_rd] && !(w_wr && (i_wa == i_issue_rd));
    assign w_stall = i_issue_valid && (w_rs1_busy || w_rs2_busy || w_waw);
    assign w_set   = i_issue_valid && !w_stall && (i_issue_rd != '0) && !i_flush;

    assign w_inc = w_set && !r_busy[i_issue_rd];
    assign w_dec = w_wr && r_busy[i_wa] && !(w_set && (i_wa == i_issue_rd));

    always_comb begin
        w_busy_nxt = r_busy;
        w_cnt_nxt  = r_cnt + {{AW{1'b0}}, w_inc} - {{AW{1'b0}}, w_dec};
        if (i_flush) begin
            w_busy_nxt = '0;
            w_cnt_nxt  = '0;
        end else begin
            if (w_wr) w_busy_nxt[i_wa] = 1'b0;
            if (w_set) w_busy_nxt[i_issue_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy <= '0;
            r_cnt  <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            r_cnt  <= w_cnt_nxt;
        end
    end

    assign o_rs1_busy = w_rs1_busy;
    assign o_rs2_busy = w_rs2_busy;
    assign o_stall    = w_stall;
    assign o_busy_cnt = r_cnt;

endmodule

// File: rtl/regfile_sb.sv
// Two-read/one-write register file with x0 hardwired to zero and a busy-bit scoreboard.
// Defining REGFILE_SB_BYPASS_EN forwards same-cycle writeback data to the read ports.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int XLEN  = REGFILE_XLEN,
    parameter int NREGS = REGFILE_NREGS
) (
    input logic         clk,
    input logic         rst_n,
    regfile_sb_if.slave bus
);

    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0] r_regs [NREGS];
    logic            w_wr;
    logic            w_byp1;
    logic            w_byp2;

    assign w_wr = bus.we && (bus.wa != '0);

`ifdef REGFILE_SB_BYPASS_EN
    // Gated by rst_n so the read ports stay quiet while reset is held.
    assign w_byp1 = rst_n && w_wr && (bus.wa == bus.rs1);
    assign w_byp2 = rst_n && w_wr && (bus.wa == bus.rs2);
`else
    assign w_byp1 = 1'b0;
    assign w_byp2 = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
        end else if (w_wr) begin
            r_regs[bus.wa] <= bus.wd;
        end
    end

    always_comb begin
        bus.rd1 = '0;
        bus.rd2 = '0;
        if (w_byp1) bus.rd1 = bus.wd;
        else if (bus.rs1 != '0) bus.rd1 = r_regs[bus.rs1];
        if (w_byp2) bus.rd2 = bus.wd;
        else if (bus.rs2 != '0) bus.rd2 = r_regs[bus.rs2];
    end

    regfile_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_sb (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_rs1         (bus.rs1),
        .i_rs2         (bus.rs2),
        .i_we          (bus.we),
        .i_wa          (bus.wa),
        .i_issue_valid (bus.issue_valid),
        .i_issue_rd    (bus.issue_rd),
        .i_flush       (bus.flush),
        .o_rs1_busy    (bus.rs1_busy),
        .o_rs2_busy    (bus.rs2_busy),
        .o_stall       (bus.stall),
        .o_busy_cnt    (bus.busy_cnt)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: expectations are queued as stimulus is applied
// and popped against DUT outputs once they are due.
module tb_regfile_sb;
    import regfile_pkg::*;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;

`ifdef REGFILE_SB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    regfile_sb_if #(.XLEN(XLEN), .NREGS(NREGS)) bus ();

    regfile_sb #(.XLEN(XLEN), .NREGS(NREGS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int    n_cmp = 0;
    int    n_err = 0;
    string q_tag[$];
    word_t q_exp[$];

    task automatic expect_val(input string tag, input word_t e);
        q_tag.push_back(tag);
        q_exp.push_back(e);
    endtask

    task automatic observe(input word_t obs);
        string tag;
        word_t e;
        n_cmp++;
        if (q_exp.size() == 0) begin
            n_err++;
            $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
        end else begin
            tag = q_tag.pop_front();
            e   = q_exp.pop_front();
            assert (obs === e) else begin
                n_err++;
                $error("FAIL %s observed=%0h expected=%0h", tag, obs, e);
            end
        end
    endtask

    task automatic idle();
        bus.rs1 = '0; bus.rs2 = '0;
        bus.we = 1'b0; bus.wa = '0; bus.wd = '0;
        bus.issue_valid = 1'b0; bus.issue_rd = '0;
        bus.flush = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_issue(input int r);
        idle();
        bus.issue_valid = 1'b1;
        bus.issue_rd = reg_idx_t'(r);
        tick();
    endtask

    task automatic do_write(input int r, input word_t d);
        idle();
        bus.we = 1'b1; bus.wa = reg_idx_t'(r); bus.wd = d;
        tick();
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        tick();
        // reset overrides in-flight write/issue
        bus.we = 1'b1; bus.wa = 5'd5; bus.wd = 32'hCAFE0001;
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd5; bus.rs1 = 5'd5;
        expect_val("reset_busy_cnt", 32'd0);
        expect_val("reset_rd1", 32'd0);
        expect_val("reset_stall", 32'd0);
        expect_val("reset_rs1_busy", 32'd0);
        tick();
        observe(32'(bus.busy_cnt));
        observe(bus.rd1);
        observe(32'(bus.stall));
        observe(32'(bus.rs1_busy));
        idle();
        rst_n = 1'b1;
        tick();

        // write x5 then reset
        do_write(5, 32'hDEADBEEF);
        bus.rs1 = 5'd5;
        expect_val("x5_readback", 32'hDEADBEEF);
        settle();
        observe(bus.rd1);
        rst_n = 1'b0;
        expect_val("x5_after_reset", 32'd0);
        expect_val("cnt_after_reset", 32'd0);
        tick();
        observe(bus.rd1);
        observe(32'(bus.busy_cnt));
        rst_n = 1'b1;
        tick();

        // x0 protection
        do_write(0, 32'hFFFFFFFF);
        expect_val("x0_rd1", 32'd0);
        expect_val("x0_rd2", 32'd0);
        settle();
        observe(bus.rd1);
        observe(bus.rd2);
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd0;
        expect_val("x0_issue_stall", 32'd0);
        settle();
        observe(32'(bus.stall));
        expect_val("x0_issue_cnt", 32'd0);
        tick();
        observe(32'(bus.busy_cnt));

        do_write(10, 32'hA5A5_5A5A);
        bus.rs2 = 5'd10;
        expect_val("x10_rd2", 32'hA5A5_5A5A);
        settle();
        observe(bus.rd2);

        // RAW / WAW stall
        do_issue(4);
        expect_val("x4_issue_cnt", 32'd1);
        observe(32'(bus.busy_cnt));
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd8; bus.rs2 = 5'd4;
        expect_val("raw_rs2_busy", 32'd1);
        expect_val("raw_stall", 32'd1);
        settle();
        observe(32'(bus.rs2_busy));
        observe(32'(bus.stall));
        expect_val("raw_cnt_hold", 32'd1);
        tick();
        observe(32'(bus.busy_cnt));
        idle();
        bus.rs1 = 5'd8;
        expect_val("stalled_x8_not_busy", 32'd0);
        settle();
        observe(32'(bus.rs1_busy));
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd4; bus.rs1 = 5'd0;
        expect_val("waw_stall", 32'd1);
        settle();
        observe(32'(bus.stall));
        tick();
        do_write(4, 32'h0000_0044);
        bus.rs1 = 5'd4;
        expect_val("x4_wb_cnt", 32'd0);
        expect_val("x4_wb_busy", 32'd0);
        expect_val("x4_wb_data", 32'h0000_0044);
        settle();
        observe(32'(bus.busy_cnt));
        observe(32'(bus.rs1_busy));
        observe(bus.rd1);

        // bypass / no-bypass on writeback of a busy register
        do_write(7, 32'h0000_0077);
        do_issue(7);
        bus.we = 1'b1; bus.wa = 5'd7; bus.wd = 32'h12345678;
        bus.rs1 = 5'd7; bus.rs2 = 5'd7;
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd11;
        expect_val("wb7_rd1", BYP ? 32'h12345678 : 32'h0000_0077);
        expect_val("wb7_rd2", BYP ? 32'h12345678 : 32'h0000_0077);
        expect_val("wb7_rs1_busy", BYP ? 32'd0 : 32'd1);
        expect_val("wb7_stall", BYP ? 32'd0 : 32'd1);
        settle();
        observe(bus.rd1);
        observe(bus.rd2);
        observe(32'(bus.rs1_busy));
        observe(32'(bus.stall));
        expect_val("wb7_cnt", BYP ? 32'd1 : 32'd0);
        tick();
        observe(32'(bus.busy_cnt));
        idle();
        bus.rs1 = 5'd7;
        expect_val("x7_after_wb", 32'h12345678);
        expect_val("x7_busy_after_wb", 32'd0);
        settle();
        observe(bus.rd1);
        observe(32'(bus.rs1_busy));
        do_write(11, 32'h0000_0011);
        expect_val("clear_x11_cnt", 32'd0);
        observe(32'(bus.busy_cnt));
        do_write(12, 32'h0000_0012);
        expect_val("clear_notbusy_cnt", 32'd0);
        observe(32'(bus.busy_cnt));

        // issue / writeback collision on x3
        do_issue(3);
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd3;
        bus.we = 1'b1; bus.wa = 5'd3; bus.wd = 32'h0000_0333;
        expect_val("collide_stall", 32'd0);
        settle();
        observe(32'(bus.stall));
        expect_val("collide_cnt", 32'd1);
        tick();
        observe(32'(bus.busy_cnt));
        idle();
        bus.rs1 = 5'd3;
        expect_val("collide_busy", 32'd1);
        expect_val("collide_data", 32'h0000_0333);
        settle();
        observe(32'(bus.rs1_busy));
        observe(bus.rd1);
        do_write(3, 32'h0000_0003);

        // set one register while retiring another
        do_issue(1);
        idle();
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd2;
        bus.we = 1'b1; bus.wa = 5'd1; bus.wd = 32'h1;
        expect_val("swap_cnt", 32'd1);
        tick();
        observe(32'(bus.busy_cnt));
        do_write(2, 32'h2);

        // flush with simultaneous issue and data write
        do_issue(1);
        do_issue(2);
        do_issue(3);
        expect_val("three_busy_cnt", 32'd3);
        observe(32'(bus.busy_cnt));
        idle();
        bus.flush = 1'b1; bus.issue_valid = 1'b1; bus.issue_rd = 5'd9;
        bus.we = 1'b1; bus.wa = 5'd12; bus.wd = 32'h0000_00C0;
        expect_val("flush_cnt", 32'd0);
        tick();
        observe(32'(bus.busy_cnt));
        idle();
        bus.rs1 = 5'd9; bus.rs2 = 5'd2;
        expect_val("flush_x9_busy", 32'd0);
        expect_val("flush_x2_busy", 32'd0);
        settle();
        observe(32'(bus.rs1_busy));
        observe(32'(bus.rs2_busy));
        bus.rs1 = 5'd12;
        expect_val("flush_write_x12", 32'h0000_00C0);
        settle();
        observe(bus.rd1);

        // fill the scoreboard to its maximum
        for (int r = 1; r < NREGS; r++) do_issue(r);
        expect_val("max_cnt", 32'(NREGS - 1));
        observe(32'(bus.busy_cnt));
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd31;
        expect_val("max_waw_stall", 32'd1);
        settle();
        observe(32'(bus.stall));
        expect_val("max_cnt_hold", 32'(NREGS - 1));
        tick();
        observe(32'(bus.busy_cnt));
        idle();
        bus.flush = 1'b1;
        tick();

        // reset while producers and writes are in flight
        do_issue(20);
        idle();
        rst_n = 1'b0;
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd21;
        bus.we = 1'b1; bus.wa = 5'd10; bus.wd = 32'h0BAD_0BAD;
        expect_val("midrst_cnt", 32'd0);
        tick();
        observe(32'(bus.busy_cnt));
        bus.rs1 = 5'd10; bus.rs2 = 5'd20;
        expect_val("midrst_rd1", 32'd0);
        expect_val("midrst_rs2_busy", 32'd0);
        expect_val("midrst_stall", 32'd0);
        settle();
        observe(bus.rd1);
        observe(32'(bus.rs2_busy));
        observe(32'(bus.stall));
        idle();
        rst_n = 1'b1;
        tick();

        if (q_exp.size() != 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", q_exp.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
